// File: rtl/wb_ic_pkg.sv
// Shared types and constants for the user-area Wishbone interconnect.
// Holds the FSM state encoding, CSR register offsets and error response words.
package wb_ic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] CSR_MASK   = 2'd0;
  localparam logic [1:0] CSR_PEND   = 2'd1;
  localparam logic [1:0] CSR_STATUS = 2'd2;
  localparam logic [1:0] CSR_TOCNT  = 2'd3;

  localparam logic [31:0] ERR_DECODE  = 32'hBADA_DD00;
  localparam logic [31:0] ERR_TIMEOUT = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_ic_irq_ctrl.sv
// Interrupt aggregation: rising-edge detect per source, pending/mask registers
// and a registered OR of the masked pending bits.
module wb_ic_irq_ctrl #(
  parameter int unsigned NSLV = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSLV-1:0] irq_src,
  input  logic [NSLV-1:0] mask_wen,
  input  logic [NSLV-1:0] mask_wdata,
  input  logic [NSLV-1:0] pend_clr,
  output logic [NSLV-1:0] mask,
  output logic [NSLV-1:0] pend,
  output logic            irq
);

  logic [NSLV-1:0] src_prev;
  logic [NSLV-1:0] rise;

  assign rise = irq_src & ~src_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_prev <= '0;
      mask     <= '0;
      pend     <= '0;
      irq      <= 1'b0;
    end else begin
      src_prev <= irq_src;
      mask     <= (mask & ~mask_wen) | (mask_wdata & mask_wen);
      // a new edge overrides a simultaneous write-one-to-clear
      pend     <= (pend & ~pend_clr) | rise;
      irq      <= |(pend & mask);
    end
  end

endmodule

// File: rtl/wb_user_interconnect.sv
// Wishbone fabric from the mgmt SoC slave port to NSLV user peripherals, with a
// local CSR region, per-access timeout watchdog and interrupt aggregation.
module wb_user_interconnect
  import wb_ic_pkg::*;
#(
  parameter int unsigned NSLV      = 4,
  parameter int unsigned DW        = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned SLV_SHIFT = 20,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [DW-1:0]      wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [DW-1:0]      wbs_dat_o,
  output logic [NSLV-1:0]    m_cyc_o,
  output logic [NSLV-1:0]    m_stb_o,
  output logic               m_we_o,
  output logic [3:0]         m_sel_o,
  output logic [31:0]        m_adr_o,
  output logic [DW-1:0]      m_dat_o,
  input  logic [NSLV*DW-1:0] m_dat_i,
  input  logic [NSLV-1:0]    m_ack_i,
  input  logic [NSLV-1:0]    irq_src_i,
  output logic [2:0]         user_irq
);

  localparam logic [31:0] WINDOW      = 32'((NSLV + 1) << SLV_SHIFT);
  localparam logic [31:0] REGION_MASK = 32'((64'd1 << SLV_SHIFT) - 64'd1);

  state_t          state;
  logic [3:0]      idx;
  logic [15:0]     wd;
  logic            to_flag;
  logic [3:0]      to_idx;
  logic [15:0]     tocnt;

  logic [31:0]     offset;
  logic [3:0]      region;
  logic            req, in_window, is_csr, csr_wr;
  logic [NSLV-1:0] onehot, lane_en, mask, pend, mask_wen, pend_clr;
  logic            sel_ack, irq_any;
  logic [DW-1:0]   sel_dat, csr_rdata;
  logic [15:0]     wd_next;

  assign req       = wbs_cyc_i && wbs_stb_i;
  assign offset    = wbs_adr_i - BASE_ADDR;
  assign in_window = (wbs_adr_i >= BASE_ADDR) && (offset < WINDOW);
  assign region    = wbs_adr_i[SLV_SHIFT+3:SLV_SHIFT];
  assign is_csr    = (region == 4'(NSLV));
  assign csr_wr    = (state == ST_IDLE) && req && in_window && is_csr && wbs_we_i;
  assign wd_next   = wd + 16'd1;

  always_comb begin
    onehot  = '0;
    lane_en = '0;
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (region == 4'(i)) onehot[i] = 1'b1;
      lane_en[i] = wbs_sel_i[i/8];
      if (idx == 4'(i)) begin
        sel_ack = m_ack_i[i];
        sel_dat = m_dat_i[i*DW +: DW];
      end
    end
  end

  assign mask_wen = (csr_wr && wbs_adr_i[3:2] == CSR_MASK) ? lane_en : '0;
  assign pend_clr = (csr_wr && wbs_adr_i[3:2] == CSR_PEND) ? (wbs_dat_i[NSLV-1:0] & lane_en) : '0;

  always_comb begin
    csr_rdata = '0;
    case (wbs_adr_i[3:2])
      CSR_MASK:   csr_rdata[NSLV-1:0] = mask;
      CSR_PEND:   csr_rdata[NSLV-1:0] = pend;
      CSR_STATUS: csr_rdata = {20'd0, to_idx, 7'd0, to_flag};
      default:    csr_rdata = {16'd0, tocnt};
    endcase
  end

  wb_ic_irq_ctrl #(.NSLV(NSLV)) u_irq (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .irq_src    (irq_src_i),
    .mask_wen   (mask_wen),
    .mask_wdata (wbs_dat_i[NSLV-1:0]),
    .pend_clr   (pend_clr),
    .mask       (mask),
    .pend       (pend),
    .irq        (irq_any)
  );

  assign user_irq = {1'b0, to_flag, irq_any};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      idx       <= '0;
      wd        <= '0;
      to_flag   <= 1'b0;
      to_idx    <= '0;
      tocnt     <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      m_cyc_o   <= '0;
      m_stb_o   <= '0;
      m_we_o    <= 1'b0;
      m_sel_o   <= '0;
      m_adr_o   <= '0;
      m_dat_o   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (!in_window) begin
              wbs_dat_o <= ERR_DECODE;
              state     <= ST_RESP;
            end else if (is_csr) begin
              wbs_dat_o <= wbs_we_i ? '0 : csr_rdata;
              if (csr_wr && wbs_adr_i[3:2] == CSR_STATUS && wbs_sel_i[0] && wbs_dat_i[0])
                to_flag <= 1'b0;
              state <= ST_RESP;
            end else begin
              idx     <= region;
              m_cyc_o <= onehot;
              m_stb_o <= onehot;
              m_we_o  <= wbs_we_i;
              m_sel_o <= wbs_sel_i;
              m_adr_o <= wbs_adr_i & REGION_MASK;
              m_dat_o <= wbs_dat_i;
              wd      <= '0;
              state   <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (!wbs_cyc_i) begin
            m_cyc_o <= '0;
            m_stb_o <= '0;
            state   <= ST_IDLE;
          end else if (sel_ack) begin
            m_cyc_o   <= '0;
            m_stb_o   <= '0;
            wbs_dat_o <= m_we_o ? '0 : sel_dat;
            wbs_ack_o <= 1'b1;
            state     <= ST_RESP;
          end else if (wd_next == 16'(TIMEOUT)) begin
            // wd counts completed BUSY cycles, so the strobe lives TIMEOUT cycles
            m_cyc_o   <= '0;
            m_stb_o   <= '0;
            wbs_dat_o <= ERR_TIMEOUT;
            wbs_ack_o <= 1'b1;
            to_flag   <= 1'b1;
            to_idx    <= idx;
            if (tocnt != 16'hFFFF) tocnt <= tocnt + 16'd1;
            state     <= ST_RESP;
          end else begin
            wd <= wd_next;
          end
        end
        ST_RESP: begin
          // slave/timeout paths enter with ack already set; CSR/miss raise it here
          if (wbs_ack_o) begin
            wbs_ack_o <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            wbs_ack_o <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
